bubble_sort_ctrl: RTL
=====================

// Module: bubble_sort_ctrl
//
// PURPOSE
//  Sequential sorting unit built around a single shared NBITS greater-than
//  comparator (combinational, strict in0 > in1).
//  - Accepts NELEMS values one per handshake and sorts them in place into
//    ascending order, one adjacent compare-and-swap per cycle.
//  - Streams the sorted values back out.
//  - Sits between a val/rdy producer and consumer; the FSM schedules all
//    comparator use.
//
// PARAMETERS
//  NBITS   4   element width; equals the comparator width
//  NELEMS  4   elements per batch (>=2); sort phase = (NELEMS-1)^2 cycles
//
// PORTS
//  clk        in   1      clock, rising-edge
//  rst        in   1      asynchronous, active-high reset
//  in_val     in   1      producer has a valid element on in_msg
//  in_rdy     out  1      unit accepts an element this cycle
//  in_msg     in   NBITS  input element
//  out_val    out  1      out_msg holds a valid sorted element
//  out_rdy    in   1      consumer accepts out_msg this cycle
//  out_msg    out  NBITS  sorted element, smallest first
//  busy       out  1      1 while in the SORT state
//
// BEHAVIOUR
//  - Reset (async, immediate):
//    - state=LOAD; all counters=0; buffer entries=0.
//    - in_rdy=0 while rst is high; out_val=0, busy=0, out_msg=0.
//  - Reset mid-operation: batch discarded; no partial output.
//  - Transfer occurs only when val&rdy are both high at a rising edge.
//  - LOAD:
//    - in_rdy=1.
//    - Each transfer writes buf[wcnt] and increments wcnt.
//    - The transfer with wcnt==NELEMS-1 goes to SORT with wcnt=0.
//  - SORT:
//    - in_rdy=0, busy=1.
//    - Index i steps 0..NELEMS-2; the pass counter steps 0..NELEMS-2.
//    - Each cycle compares buf[i] > buf[i+1] on the shared comparator and
//      swaps the pair at the clock edge if true.
//    - Equal values never swap, so the sort is stable.
//    - After exactly (NELEMS-1)^2 cycles, go to DRAIN (9 cycles for N=4).
//  - DRAIN:
//    - out_val=1; out_msg=buf[rcnt], held stable while out_rdy=0.
//    - Each transfer increments rcnt.
//    - The transfer at rcnt==NELEMS-1 goes to LOAD with rcnt=0.
//  - Latency: 4th input accepted at edge t -> SORT for t..t+9 ->
//    out_val=1 in the cycle after edge t+9 (N=4).
//  - in_val is ignored outside LOAD; out_rdy is ignored outside DRAIN.
//  - Input and output never overlap, so there are no simultaneous
//    transfers.
//  - Back-to-back batches:
//    - in_rdy=1 in the cycle immediately after the last output transfer.
//    - No idle cycle is inserted.
//  - Counter widths: clog2(NELEMS) bits; counters never wrap past
//    NELEMS-1.
//  - Comparator: sole instance; no other magnitude compare in the block.
//
// TESTING
//  1. Reset: hold rst -> in_rdy=0, out_val=0, busy=0; release ->
//     in_rdy=1.
//  2. Load 3,1,2,0 with out_rdy=1 -> busy for 9 cycles -> out 0,1,2,3.
//  3. Load 15,15,0,15 -> out 0,15,15,15; already-sorted 1,2,3,4 -> same
//     order, 9 cycles.
//  4. Random out_rdy stalls while draining 9,4,4,7 -> out_msg stable when
//     stalled; out 4,4,7,9.
//  5. Async rst pulse mid-SORT after loading 5,6,2,1 -> state LOAD, no
//     out_val; then 8,0,8,1 -> out 0,1,8,8.
//  6. in_val=1 held during SORT/DRAIN -> no extra elements captured;
//     next batch accepted immediately.

Source files
------------

// File: rtl/bubble_sort_ctrl.sv
// Load/sort/drain bubble sorter. A single shared greater-than comparator does
// one adjacent compare-and-swap per cycle during the SORT phase.
module bubble_sort_ctrl #(
    parameter int unsigned NBITS  = 4,
    parameter int unsigned NELEMS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_msg,
    output logic             busy
);

    localparam int unsigned CW = $clog2(NELEMS);
    localparam logic [CW-1:0] LAST      = CW'(NELEMS - 1);
    localparam logic [CW-1:0] LAST_PAIR = CW'(NELEMS - 2);

    typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic [CW-1:0]    rcnt_q, rcnt_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    pass_q, pass_d;
    logic [CW-1:0]    idx_nxt;
    logic [NBITS-1:0] mem_q [NELEMS];

    logic [NBITS-1:0] cmp_a, cmp_b;
    logic             cmp_gt;
    logic             in_fire;
    logic             do_swap;

    // The one and only magnitude comparator in the block.
    assign idx_nxt = idx_q + CW'(1);
    assign cmp_a   = mem_q[idx_q];
    assign cmp_b   = mem_q[idx_nxt];
    assign cmp_gt  = cmp_a > cmp_b;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        in_rdy  = 1'b0;
        out_val = 1'b0;
        out_msg = '0;
        busy    = 1'b0;
        in_fire = 1'b0;
        do_swap = 1'b0;

        unique case (state_q)
            StLoad: begin
                in_rdy  = ~rst;
                in_fire = in_val & ~rst;
                if (in_fire) begin
                    if (wcnt_q == LAST) begin
                        wcnt_d  = '0;
                        state_d = StSort;
                    end else begin
                        wcnt_d = wcnt_q + CW'(1);
                    end
                end
            end
            StSort: begin
                busy    = 1'b1;
                // Strict compare: equal neighbours stay put, keeping the sort stable.
                do_swap = cmp_gt;
                if (idx_q == LAST_PAIR) begin
                    idx_d = '0;
                    if (pass_q == LAST_PAIR) begin
                        pass_d  = '0;
                        state_d = StDrain;
                    end else begin
                        pass_d = pass_q + CW'(1);
                    end
                end else begin
                    idx_d = idx_nxt;
                end
            end
            StDrain: begin
                out_val = 1'b1;
                out_msg = mem_q[rcnt_q];
                if (out_rdy) begin
                    if (rcnt_q == LAST) begin
                        rcnt_d  = '0;
                        state_d = StLoad;
                    end else begin
                        rcnt_d = rcnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            for (int k = 0; k < int'(NELEMS); k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            if (in_fire) begin
                mem_q[wcnt_q] <= in_msg;
            end
            if (do_swap) begin
                mem_q[idx_q]   <= cmp_b;
                mem_q[idx_nxt] <= cmp_a;
            end
        end
    end

endmodule
